// File: rtl/audio_sample_player_pkg.sv
// Sound-effect sample table and shared types for the audio sample player.
// Each sample occupies an inclusive [start, end] range of the sample ROM.
package audio_sample_player_pkg;

   localparam int SAMPLE_BITS = 3;
   localparam int ROM_AW      = 14;

   typedef logic [SAMPLE_BITS-1:0] sample_sel_t;
   typedef logic [ROM_AW-1:0]      rom_addr_t;

   localparam sample_sel_t SAMPLE_LOST_BALL   = 3'd0;
   localparam sample_sel_t SAMPLE_BLOCK_START = 3'd1;
   localparam sample_sel_t SAMPLE_PADDLE      = 3'd2;
   localparam sample_sel_t SAMPLE_WALLS       = 3'd3;
   localparam sample_sel_t SAMPLE_COUNT       = 3'd4;

   typedef enum logic {
      ST_IDLE,
      ST_PLAYING
   } play_state_t;

   function automatic rom_addr_t sample_start(input sample_sel_t sel);
      case (sel)
         SAMPLE_LOST_BALL:   sample_start = 14'd16;
         SAMPLE_BLOCK_START: sample_start = 14'd32;
         SAMPLE_PADDLE:      sample_start = 14'd48;
         SAMPLE_WALLS:       sample_start = 14'd64;
         default:            sample_start = '0;
      endcase
   endfunction

   // End addresses are the last valid word of each sample.
   function automatic rom_addr_t sample_end(input sample_sel_t sel);
      case (sel)
         SAMPLE_LOST_BALL:   sample_end = 14'd19;
         SAMPLE_BLOCK_START: sample_end = 14'd35;
         SAMPLE_PADDLE:      sample_end = 14'd50;
         SAMPLE_WALLS:       sample_end = 14'd67;
         default:            sample_end = '0;
      endcase
   endfunction

endpackage

// File: rtl/audio_sample_player_pwm.sv
// 1-bit PWM modulator: free-running counter compared against the PCM level.
// Output is registered; duty is pcm/2^PCM_BITS.
module audio_sample_player_pwm #(
   parameter int PCM_BITS = 8
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic [PCM_BITS-1:0] pcm,
   output logic                pwm
);

   logic [PCM_BITS-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt <= '0;
         pwm <= 1'b0;
      end else begin
         cnt <= cnt + 1'b1;
         pwm <= (pcm > cnt);
      end
   end

endmodule

// File: rtl/audio_sample_player.sv
// Plays a selected PCM sound effect from the sample ROM at a fixed rate.
// The PCM level drives a PWM modulator on the audio pin.
module audio_sample_player
   import audio_sample_player_pkg::*;
#(
   parameter int SAMPLE_DIV    = 6250,
   parameter int PCM_BITS      = 8,
   parameter int ROM_ADDR_BITS = 14
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [SAMPLE_BITS-1:0]   AUDIO_SELECT,
   input  logic                     AUDIO_TRIGGER,
   output logic [ROM_ADDR_BITS-1:0] ROM_ADDR,
   input  logic [PCM_BITS-1:0]      ROM_DATA,
   output logic                     AUDIO_PWM,
   output logic                     PLAYING
);

   localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [PCM_BITS-1:0] PCM_MID =
      {1'b1, {(PCM_BITS-1){1'b0}}};

   play_state_t state, state_nxt;

   logic [DIV_W-1:0]         divider;
   logic [DIV_W-1:0]         hold_cnt;
   logic [ROM_ADDR_BITS-1:0] end_addr;
   logic [PCM_BITS-1:0]      pcm;
   logic                     tail;
   logic                     trig_ok;
   logic                     tick;
   logic                     last;

   assign trig_ok = AUDIO_TRIGGER && (AUDIO_SELECT < SAMPLE_COUNT);
   assign tick    = (state == ST_PLAYING) && (divider == DIV_LAST);
   assign last    = tick && (ROM_ADDR == end_addr);

   always_ff @(posedge CLK) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // A trigger outranks the final tick so back-to-back effects never gap.
   always_comb begin
      state_nxt = state;
      if (trig_ok)   state_nxt = ST_PLAYING;
      else if (last) state_nxt = ST_IDLE;
   end

   always_comb begin
      PLAYING = (state == ST_PLAYING);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ROM_ADDR <= '0;
         end_addr <= '0;
         divider  <= '0;
         hold_cnt <= '0;
         tail     <= 1'b0;
         pcm      <= PCM_MID;
      end else begin
         if (trig_ok) begin
            ROM_ADDR <= ROM_ADDR_BITS'(sample_start(AUDIO_SELECT));
            end_addr <= ROM_ADDR_BITS'(sample_end(AUDIO_SELECT));
            divider  <= '0;
            hold_cnt <= '0;
            tail     <= 1'b0;
         end else if (state == ST_PLAYING) begin
            divider <= tick ? '0 : divider + 1'b1;
            if (tick && !last) ROM_ADDR <= ROM_ADDR + 1'b1;
            if (last) begin
               tail     <= 1'b1;
               hold_cnt <= '0;
            end
         end else if (tail) begin
            // Hold the final sample one full sample period, then go silent.
            if (hold_cnt == DIV_LAST) begin
               tail     <= 1'b0;
               hold_cnt <= '0;
               pcm      <= PCM_MID;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
         if (tick) pcm <= ROM_DATA;
      end
   end

   audio_sample_player_pwm #(
      .PCM_BITS(PCM_BITS)
   ) u_pwm (
      .CLK   (CLK),
      .RESET (RESET),
      .pcm   (pcm),
      .pwm   (AUDIO_PWM)
   );

endmodule

// File: tb/tb_audio_sample_player.sv
// Directed bench for audio_sample_player with a 4-cycle sample period.
// ROM model returns the low address byte one cycle after the address.
module tb_audio_sample_player;

   logic        CLK;
   logic        RESET;
   logic [2:0]  AUDIO_SELECT;
   logic        AUDIO_TRIGGER;
   logic [13:0] ROM_ADDR;
   logic [7:0]  ROM_DATA;
   logic        AUDIO_PWM;
   logic        PLAYING;

   int n_chk;
   int n_pass;
   int ones;
   logic stayed;

   audio_sample_player #(
      .SAMPLE_DIV   (4),
      .PCM_BITS     (8),
      .ROM_ADDR_BITS(14)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .AUDIO_SELECT (AUDIO_SELECT),
      .AUDIO_TRIGGER(AUDIO_TRIGGER),
      .ROM_ADDR     (ROM_ADDR),
      .ROM_DATA     (ROM_DATA),
      .AUDIO_PWM    (AUDIO_PWM),
      .PLAYING      (PLAYING)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) ROM_DATA <= ROM_ADDR[7:0];

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic trigger(input logic [2:0] sel);
      AUDIO_SELECT  = sel;
      AUDIO_TRIGGER = 1'b1;
      step(1);
      AUDIO_TRIGGER = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      RESET = 1'b1;
      AUDIO_SELECT = 3'd0;
      AUDIO_TRIGGER = 1'b0;
      step(2);
      check("rst_playing", PLAYING, 0);
      check("rst_pwm", AUDIO_PWM, 0);
      check("rst_pcm", dut.pcm, 8'h80);
      check("rst_addr", ROM_ADDR, 0);
      check("rst_div", dut.divider, 0);
      RESET = 1'b0;

      ones = 0;
      for (int i = 0; i < 256; i++) begin
         step(1);
         ones += int'(AUDIO_PWM);
      end
      check("idle_duty", ones, 128);

      // Sample 0: addresses 16..19
      trigger(3'd0);
      check("a_playing", PLAYING, 1);
      check("a_addr", ROM_ADDR, 16);
      check("a_pcm_pre", dut.pcm, 8'h80);
      for (int i = 0; i < 4; i++) begin
         step(4);
         check("a_pcm", dut.pcm, 32'h10 + i);
         check("a_play", PLAYING, (i < 3) ? 1 : 0);
      end
      check("a_end_addr", ROM_ADDR, 19);
      step(3);
      check("a_tail_hold", dut.pcm, 8'h13);
      check("a_tail_div", dut.divider, 0);
      step(1);
      check("a_silence", dut.pcm, 8'h80);

      // Retrigger sample 1 six cycles into sample 0
      trigger(3'd0);
      step(5);
      trigger(3'd1);
      check("rt_addr", ROM_ADDR, 32);
      check("rt_playing", PLAYING, 1);
      check("rt_pcm_old", dut.pcm, 8'h10);
      step(3);
      check("rt_pcm_hold", dut.pcm, 8'h10);
      step(1);
      check("rt_pcm_new", dut.pcm, 8'h20);
      step(20);
      check("rt_done", PLAYING, 0);
      check("rt_silence", dut.pcm, 8'h80);
      check("rt_end_addr", ROM_ADDR, 35);

      // Out-of-range selects are ignored
      trigger(3'd4);
      check("bad4_playing", PLAYING, 0);
      check("bad4_addr", ROM_ADDR, 35);
      trigger(3'd7);
      check("bad7_playing", PLAYING, 0);
      check("bad7_addr", ROM_ADDR, 35);

      // Trigger on the final tick of sample 2 (48..50)
      trigger(3'd2);
      step(11);
      check("ft_pcm_mid", dut.pcm, 8'h31);
      trigger(3'd3);
      check("ft_playing", PLAYING, 1);
      check("ft_addr", ROM_ADDR, 64);
      stayed = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         stayed &= PLAYING;
      end
      check("ft_no_drop", stayed, 1);
      check("ft_pcm_new", dut.pcm, 8'h40);

      // Reset mid-playback
      step(6);
      RESET = 1'b1;
      step(1);
      check("mr_playing", PLAYING, 0);
      check("mr_pcm", dut.pcm, 8'h80);
      check("mr_div", dut.divider, 0);
      check("mr_pwm", AUDIO_PWM, 0);
      RESET = 1'b0;
      step(8);
      check("mr_stay_idle", PLAYING, 0);
      check("mr_no_tail", dut.pcm, 8'h80);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
